// File: rtl/lamsu_pkg.sv
// lamsu_pkg: shared Q-format constants, lane typedefs and the saturation
// helper for the gated state-update block (lam_gated_state_update).
//   lam  : Q0.16 unsigned (lam_t)
//   xt/h : Q8.8 signed    (lane_t)
//   acc_t: 35-bit signed accumulator, wide enough for h*lam + xt*(1-lam)
package lamsu_pkg;

  localparam int FRAC_XT  = 8;
  localparam int FRAC_LAM = 16;
  localparam int ONE_Q016 = 65536;

  typedef logic signed [15:0] lane_t;
  typedef logic        [15:0] lam_t;
  typedef logic signed [34:0] acc_t;

  // Clamp an accumulator value (already shifted back to Q8.8) into 16 bits.
  function automatic lane_t sat16(input acc_t v);
    if (v > acc_t'(32767)) begin
      return 16'sh7FFF;
    end else if (v < acc_t'(-32768)) begin
      return 16'sh8000;
    end else begin
      return lane_t'(v[15:0]);
    end
  endfunction

endpackage

// File: rtl/lamsu_lane_mac.sv
// lamsu_lane_mac: one lane of h_new = lam*h_old + (1-lam)*xt.
// Purely combinational: multiply-accumulate, optional rounding, shift back
// to Q8.8, saturate.
// Configuration macro: LAMSU_ROUND_EN (defined -> round half up before the
// shift; undefined -> plain arithmetic shift, i.e. truncate toward -inf).
// Ports:
//   lam_i   : lambda, Q0.16 unsigned
//   xt_i    : input sample, Q8.8 signed
//   h_old_i : previous hidden state, Q8.8 signed
//   h_new_o : updated hidden state, Q8.8 signed (saturated)
module lamsu_lane_mac
  import lamsu_pkg::*;
(
  input  lam_t  lam_i,
  input  lane_t xt_i,
  input  lane_t h_old_i,
  output lane_t h_new_o
);

  logic [16:0] om;
  acc_t        prod_h;
  acc_t        prod_x;
  acc_t        sum;
  acc_t        rnd;
  acc_t        shifted;

  // 1 - lam in Q0.16 needs 17 bits: lam = 0 gives exactly 65536.
  assign om = 17'(ONE_Q016) - {1'b0, lam_i};

  // Both multiplicands are zero-extended before the signed multiply so the
  // unsigned lambda terms are never read as negative.
  assign prod_h = acc_t'(h_old_i) * acc_t'($signed({1'b0, lam_i}));
  assign prod_x = acc_t'(xt_i) * acc_t'($signed({1'b0, om}));
  assign sum    = prod_h + prod_x;

`ifdef LAMSU_ROUND_EN
  assign rnd = sum + acc_t'(1 << (FRAC_LAM - 1));
`else
  assign rnd = sum;
`endif

  assign shifted = rnd >>> FRAC_LAM;
  assign h_new_o = sat16(shifted);

endmodule

// File: rtl/lam_gated_state_update.sv
// lam_gated_state_update: per-channel gated recurrence stage.
// Consumes (lam, xt) tile tokens, keeps D channels of hidden state on chip
// as NUM_GRP = D/TILE_SIZE tile-wide groups and emits every updated tile.
// Configuration macro: LAMSU_ROUND_EN (rounding mode of the lane MACs).
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   in_valid/in_ready        : input token handshake
//   in_lam_vec, in_xt_vec    : TILE_SIZE lanes, lane 0 in the LSBs
//   seq_clear                : pulse, zero state, group index and step count
//   out_valid/out_ready      : output tile handshake
//   out_h_vec                : updated hidden state tile
//   out_grp_idx, out_last    : group of out_h_vec, last group flag
//   step_cnt                 : completed timesteps
//   busy                     : any pipeline stage holds a token
// Handshake: a transfer happens on a rising edge where valid && ready; a
// producer holding valid keeps its payload stable until that edge, and
// ready may depend combinationally on the consumer's state but never on
// valid of the same interface.
module lam_gated_state_update
  import lamsu_pkg::*;
#(
  parameter int TILE_SIZE  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int D          = 256,
  parameter int STEP_W     = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DATA_WIDTH*TILE_SIZE-1:0]      in_lam_vec,
  input  logic [DATA_WIDTH*TILE_SIZE-1:0]      in_xt_vec,
  input  logic                                 seq_clear,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DATA_WIDTH*TILE_SIZE-1:0]      out_h_vec,
  output logic [$clog2(D/TILE_SIZE)-1:0]       out_grp_idx,
  output logic                                 out_last,
  output logic [STEP_W-1:0]                    step_cnt,
  output logic                                 busy
);

  localparam int NUM_GRP = D / TILE_SIZE;
  localparam int GRP_W   = $clog2(D / TILE_SIZE);
  localparam int VEC_W   = DATA_WIDTH * TILE_SIZE;

  if (NUM_GRP < 2) begin : g_bad_num_grp
    $error("lam_gated_state_update: D/TILE_SIZE must be at least 2");
  end
  if (DATA_WIDTH != 16) begin : g_bad_width
    $error("lam_gated_state_update: lanes are fixed at 16 bits");
  end

  // Hidden state, one tile-wide word per group.
  logic [NUM_GRP-1:0][VEC_W-1:0] state_q;

  logic [GRP_W-1:0]  grp_q, grp_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              clear_pend_q, clear_pend_d;

  // Stage A: captured token plus the state it will update.
  logic              a_valid_q;
  logic [VEC_W-1:0]  a_lam_q, a_xt_q, a_h_q;
  logic [GRP_W-1:0]  a_grp_q;

  // Stage B: registered result, drives the output port.
  logic              out_valid_q;
  logic [VEC_W-1:0]  out_h_q;
  logic [GRP_W-1:0]  out_grp_q;

  logic [VEC_W-1:0]  b_h_vec;
  logic              adv, accept, do_clear, grp_last;

  assign busy     = a_valid_q || out_valid_q;
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = !rst && (adv || !a_valid_q) && !clear_pend_q && !seq_clear;
  assign accept   = in_valid && in_ready;
  // A clear (fresh or pending) only lands once the pipeline is empty, so it
  // can never collide with an accept or a state write.
  assign do_clear = (seq_clear || clear_pend_q) && !busy;
  assign grp_last = (grp_q == GRP_W'(NUM_GRP - 1));

  for (genvar l = 0; l < TILE_SIZE; l++) begin : g_lane
    lamsu_lane_mac u_mac (
      .lam_i   (a_lam_q[l*DATA_WIDTH +: DATA_WIDTH]),
      .xt_i    (a_xt_q[l*DATA_WIDTH +: DATA_WIDTH]),
      .h_old_i (a_h_q[l*DATA_WIDTH +: DATA_WIDTH]),
      .h_new_o (b_h_vec[l*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  always_comb begin
    grp_d        = grp_q;
    step_d       = step_q;
    clear_pend_d = clear_pend_q;
    if (do_clear) begin
      grp_d        = '0;
      step_d       = '0;
      clear_pend_d = 1'b0;
    end else begin
      if (seq_clear) begin
        clear_pend_d = 1'b1;
      end
      if (accept) begin
        grp_d = grp_last ? '0 : grp_q + GRP_W'(1);
        if (grp_last) begin
          step_d = step_q + STEP_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grp_q        <= '0;
      step_q       <= '0;
      clear_pend_q <= 1'b0;
    end else begin
      grp_q        <= grp_d;
      step_q       <= step_d;
      clear_pend_q <= clear_pend_d;
    end
  end

  // State array. The Stage B write to a group always lands at or before the
  // edge on which the same group is next read into Stage A, since groups are
  // revisited at least NUM_GRP >= 2 accepts apart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
    end else if (do_clear) begin
      state_q <= '0;
    end else if (adv && a_valid_q) begin
      state_q[a_grp_q] <= b_h_vec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid_q <= 1'b0;
      a_lam_q   <= '0;
      a_xt_q    <= '0;
      a_h_q     <= '0;
      a_grp_q   <= '0;
    end else if (accept) begin
      a_valid_q <= 1'b1;
      a_lam_q   <= in_lam_vec;
      a_xt_q    <= in_xt_vec;
      a_h_q     <= state_q[grp_q];
      a_grp_q   <= grp_q;
    end else if (adv) begin
      a_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_h_q     <= '0;
      out_grp_q   <= '0;
    end else if (adv) begin
      out_valid_q <= a_valid_q;
      if (a_valid_q) begin
        out_h_q   <= b_h_vec;
        out_grp_q <= a_grp_q;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_h_vec   = out_h_q;
  assign out_grp_idx = out_grp_q;
  assign out_last    = (out_grp_q == GRP_W'(NUM_GRP - 1));
  assign step_cnt    = step_q;

endmodule

// File: tb/tb_lam_gated_state_update.sv
// tb_lam_gated_state_update: self-checking bench for lam_gated_state_update.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge or 1 ns after a rising edge. A reference model works on
// integer arithmetic per channel and fills a scoreboard queue in accept
// order; an output monitor compares the head of the queue on every cycle
// out_valid is high.
module tb_lam_gated_state_update;

  localparam int TILE = 4;
  localparam int DW   = 16;
  localparam int D    = 256;
  localparam int NG   = D / TILE;
  localparam int VW   = DW * TILE;
  localparam int GW   = 6;
  localparam int SW   = 16;
  localparam int EW   = 1 + GW + VW;

  localparam logic [VW-1:0] LAM_HALF = {4{16'h8000}};
  localparam logic [VW-1:0] LAM_MAX  = {4{16'hFFFF}};
  localparam logic [VW-1:0] ZERO_V   = '0;
  localparam logic [VW-1:0] X256     = {4{16'h0100}};
  localparam logic [VW-1:0] XNEG     = {4{16'h8000}};
  localparam logic [VW-1:0] H128     = {4{16'h0080}};
`ifdef LAMSU_ROUND_EN
  localparam logic [VW-1:0] H_DECAY  = {4{16'h0100}};
`else
  localparam logic [VW-1:0] H_DECAY  = {4{16'h00FF}};
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [VW-1:0] in_lam_vec, in_xt_vec;
  logic          seq_clear;
  logic          out_valid, out_ready;
  logic [VW-1:0] out_h_vec;
  logic [GW-1:0] out_grp_idx;
  logic          out_last;
  logic [SW-1:0] step_cnt;
  logic          busy;

  int checks = 0;
  int errors = 0;
  bit rnd_ready = 1'b0;

  // Scoreboard entry: {last, grp, h_vec}.
  logic [EW-1:0] exp_q[$];

  // Reference model state.
  int m_h[NG][TILE];
  int m_grp;
  int m_step;

  lam_gated_state_update dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_lam_vec  (in_lam_vec),
    .in_xt_vec   (in_xt_vec),
    .seq_clear   (seq_clear),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_h_vec   (out_h_vec),
    .out_grp_idx (out_grp_idx),
    .out_last    (out_last),
    .step_cnt    (step_cnt),
    .busy        (busy)
  );

  // ---------------- clock ----------------
  initial forever #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int ref_lane(input int h, input int lam, input int xt);
    longint s;
    s = longint'(h) * longint'(lam) + longint'(xt) * longint'(65536 - lam);
`ifdef LAMSU_ROUND_EN
    s = s + 32768;
`endif
    s = s >>> 16;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return int'(s);
  endfunction

  task automatic model_reset();
    for (int g = 0; g < NG; g++)
      for (int l = 0; l < TILE; l++)
        m_h[g][l] = 0;
    m_grp  = 0;
    m_step = 0;
  endtask

  task automatic model_accept(input logic [VW-1:0] lam_v, input logic [VW-1:0] xt_v);
    logic [VW-1:0] hv;
    logic [15:0]   lf, xf;
    hv = '0;
    for (int l = 0; l < TILE; l++) begin
      lf = lam_v[l*16 +: 16];
      xf = xt_v[l*16 +: 16];
      m_h[m_grp][l] = ref_lane(m_h[m_grp][l], int'(lf), int'($signed(xf)));
      hv[l*16 +: 16] = 16'(m_h[m_grp][l]);
    end
    exp_q.push_back({(m_grp == NG - 1), GW'(m_grp), hv});
    if (m_grp == NG - 1) begin
      m_grp  = 0;
      m_step = (m_step + 1) % 65536;
    end else begin
      m_grp++;
    end
  endtask

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", out_valid, 1'b0);
      end else begin
        e = exp_q[0];
        chk("out_h_vec", out_h_vec, e[VW-1:0]);
        chk("out_grp_idx", out_grp_idx, e[VW +: GW]);
        chk("out_last", out_last, e[EW-1]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_tok(input logic [VW-1:0] lam_v, input logic [VW-1:0] xt_v);
    int n;
    n = 0;
    in_lam_vec = lam_v;
    in_xt_vec  = xt_v;
    in_valid   = 1'b1;
    forever begin
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_ready) begin
        model_accept(lam_v, xt_v);
        break;
      end
      n++;
      if (n > 100) begin
        chk("send_timeout", 1'b0, 1'b1);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    while ((busy || exp_q.size() != 0) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", (n < 50), 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_lam_vec = '0;
    in_xt_vec  = '0;
    seq_clear  = 1'b0;
    out_ready  = 1'b1;
    model_reset();

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_h_vec", out_h_vec, ZERO_V);
    chk("rst_out_grp_idx", out_grp_idx, 6'd0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_step_cnt", step_cnt, 16'd0);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_rst", in_ready, 1'b1);

    // First token: accepted at edge N, in Stage A after N, on the output
    // after N+1 and handed off at N+2.
    send_tok(LAM_HALF, X256);
    chk("lat_not_yet_valid", out_valid, 1'b0);
    chk("lat_busy", busy, 1'b1);
    @(posedge clk); #1;
    chk("lat_out_valid", out_valid, 1'b1);
    chk("first_h_128", out_h_vec, H128);
    chk("first_grp_0", out_grp_idx, 6'd0);
    chk("first_last_0", out_last, 1'b0);

    // Rest of two full sweeps: second sweep gives 192 everywhere.
    for (int i = 1; i < 2 * NG; i++) send_tok(LAM_HALF, X256);
    drain();
    chk("step_cnt_two_sweeps", step_cnt, 16'd2);

    // Random tokens with random downstream backpressure.
    rnd_ready = 1'b1;
    for (int i = 0; i < 96; i++) send_tok({$urandom, $urandom}, {$urandom, $urandom});
    drain();
    chk("step_cnt_random", step_cnt, 16'(m_step));

    // Output stall: out_ready low across five edges.
    out_ready = 1'b0;
    send_tok({$urandom, $urandom}, {$urandom, $urandom});
    send_tok({$urandom, $urandom}, {$urandom, $urandom});
    chk("stall_in_ready_low", in_ready, 1'b0);
    chk("stall_out_valid", out_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_in_ready_hold", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    send_tok({$urandom, $urandom}, {$urandom, $urandom});
    send_tok({$urandom, $urandom}, {$urandom, $urandom});
    drain();

    // Idle clear together with a valid token: the clear wins.
    in_lam_vec = LAM_HALF;
    in_xt_vec  = X256;
    in_valid   = 1'b1;
    seq_clear  = 1'b1;
    #1;
    chk("clear_blocks_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    seq_clear = 1'b0;
    in_valid  = 1'b0;
    model_reset();
    chk("idle_clear_step", step_cnt, 16'd0);
    chk("idle_clear_busy", busy, 1'b0);

    // Boundary values: build h=256 in group 0, h=0 in group 1.
    send_tok(ZERO_V, X256);
    send_tok(ZERO_V, ZERO_V);
    for (int i = 2; i < NG; i++) send_tok({$urandom, $urandom}, {$urandom, $urandom});
    drain();
    send_tok(LAM_MAX, ZERO_V);
    @(posedge clk); #1;
    chk("decay_lam_max", out_h_vec, H_DECAY);
    send_tok(ZERO_V, XNEG);
    @(posedge clk); #1;
    chk("xt_most_negative", out_h_vec, XNEG);
    drain();

    // Clear while busy: held off until the pipeline drains.
    send_tok(LAM_HALF, X256);
    send_tok(LAM_HALF, X256);
    seq_clear = 1'b1;
    #1;
    chk("busy_clear_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    seq_clear = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      chk("clear_pend_in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
      n++;
    end
    chk("clear_drain_timeout", (n < 20), 1'b1);
    chk("clear_pend_idle_in_ready", in_ready, 1'b0);
    chk("step_before_clear", step_cnt, 16'(m_step));
    @(posedge clk); #1;
    model_reset();
    chk("step_after_clear", step_cnt, 16'd0);
    chk("in_ready_after_clear", in_ready, 1'b1);
    send_tok(LAM_HALF, X256);
    @(posedge clk); #1;
    chk("post_clear_h_128", out_h_vec, H128);
    chk("post_clear_grp_0", out_grp_idx, 6'd0);
    drain();

    // Reset with both stages full.
    out_ready = 1'b0;
    send_tok(LAM_HALF, X256);
    send_tok(LAM_HALF, X256);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b0);
    chk("midrst_step", step_cnt, 16'd0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send_tok(LAM_HALF, X256);
    @(posedge clk); #1;
    chk("post_rst_h_128", out_h_vec, H128);
    chk("post_rst_grp_0", out_grp_idx, 6'd0);
    chk("post_rst_last_0", out_last, 1'b0);
    drain();
    chk("scoreboard_empty", exp_q.size(), 0);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
